// File: rtl/cmp_pkg.sv
// Shared types and constants for the cmp_arbiter slice.
// Contents: state_e (EMPTY/FULL output-stage state), req_id_t (requester id),
// CNT_W (width of the optional grant counters).
package cmp_pkg;

  localparam int unsigned CNT_W = 16;

  // Requester identifier: 0 or 1
  typedef logic req_id_t;

  // Output-stage occupancy
  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage : cmp_pkg

// File: rtl/slt_cmp.sv
// Purely combinational signed less-than for N-bit two's-complement operands.
// The difference a - b comes from one adder fed with ~b and a carry-in of 1.
// When the operand signs differ, that difference can overflow, so a's sign
// bit gives the answer directly instead.
// Ports:
//   a, b : N-bit signed operands
//   lt   : 1 when a < b (signed)
module slt_cmp #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);

  logic [N-1:0] diff;
  logic         signs_differ;

  // a - b as a + ~b + 1; the carry-out is not needed
  assign diff         = a + ~b + N'(1);
  assign signs_differ = a[N-1] ^ b[N-1];

  // Mixed signs: the negative operand is the smaller one
  assign lt = signs_differ ? a[N-1] : diff[N-1];

endmodule : slt_cmp

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter in front of a one-entry output stage that
// reports the signed comparison a < b for the accepted operand pair.
// Optional macro: CMP_ARBITER_STATS_EN adds saturating per-requester
// accept counters (grant_cnt0 / grant_cnt1).
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   req0_valid/ready, a, b   : requester 0 handshake and operands
//   req1_valid/ready, a, b   : requester 1 handshake and operands
//   resp_valid/ready         : output-stage handshake
//   resp_id                  : requester that owns the held result
//   resp_lt                  : signed a < b for the held pair
//   grant_cnt0/1             : accept counters (CMP_ARBITER_STATS_EN only)
module cmp_arbiter
  import cmp_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic         resp_id,
  output logic         resp_lt
`ifdef CMP_ARBITER_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
`endif
);

  state_e       state_q, state_d;
  req_id_t      last_grant_q, last_grant_d;
  req_id_t      id_q, id_d;
  logic [N-1:0] a_q, a_d;
  logic [N-1:0] b_q, b_d;

  logic stage_free_c;
  logic pick0_c;
  logic pick1_c;
  logic accept_c;

  // State and output-stage registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      b_q          <= b_d;
    end
  end

  // Arbitration, next state and output-stage load
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    b_d          = b_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;

    stage_free_c = (state_q == EMPTY) || resp_ready;

    // On a tie, the requester not granted last wins
    pick0_c = req0_valid && (!req1_valid || (last_grant_q == 1'b1));
    pick1_c = req1_valid && (!req0_valid || (last_grant_q == 1'b0));

    // Readies are forced low while reset is held
    if (!rst && stage_free_c) begin
      req0_ready = pick0_c;
      req1_ready = pick1_c;
    end

    accept_c = req0_ready || req1_ready;

    if (accept_c) begin
      last_grant_d = req1_ready;
      id_d         = req1_ready;
      a_d          = req1_ready ? req1_a : req0_a;
      b_d          = req1_ready ? req1_b : req0_b;
    end

    case (state_q)
      EMPTY: begin
        if (accept_c) state_d = FULL;
      end
      FULL: begin
        // A handshake with a simultaneous accept reloads and stays FULL
        if (resp_ready && !accept_c) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  slt_cmp #(
    .N(N)
  ) u_slt_cmp (
    .a (a_q),
    .b (b_q),
    .lt(resp_lt)
  );

  assign resp_valid = (state_q == FULL);
  assign resp_id    = id_q;

`ifdef CMP_ARBITER_STATS_EN
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt1_q;

  // Saturating accept counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (req0_ready && (cnt0_q != {CNT_W{1'b1}})) cnt0_q <= cnt0_q + CNT_W'(1);
      if (req1_ready && (cnt1_q != {CNT_W{1'b1}})) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule : cmp_arbiter

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter: a vector table walked cycle by cycle, plus
// hand-written sequences for reset behaviour and the optional counters.
module tb_cmp_arbiter;

  localparam int unsigned N = 32;

  logic         clk;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic         req0_ready, req1_ready;
  logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         resp_valid, resp_ready, resp_id, resp_lt;
`ifdef CMP_ARBITER_STATS_EN
  logic [15:0]  grant_cnt0, grant_cnt1;
`endif

  int checks = 0;
  int errors = 0;

  cmp_arbiter #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_id   (resp_id),
    .resp_lt   (resp_lt)
`ifdef CMP_ARBITER_STATS_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0v;
    logic        r1v;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        rr;
    logic        e_r0;
    logic        e_r1;
    logic        e_v;
    logic        e_id;
    logic        e_lt;
  } vec_t;

  localparam int NV = 14;
  vec_t vt[NV];

  function automatic vec_t mk(logic r0v, logic r1v, logic [31:0] a0, logic [31:0] b0,
                              logic [31:0] a1, logic [31:0] b1, logic rr,
                              logic e_r0, logic e_r1, logic e_v, logic e_id, logic e_lt);
    vec_t v;
    v.r0v = r0v; v.r1v = r1v; v.a0 = a0; v.b0 = b0; v.a1 = a1; v.b1 = b1;
    v.rr = rr; v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_v = e_v; v.e_id = e_id; v.e_lt = e_lt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r0v, input logic r1v, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic rr);
    req0_valid = r0v; req1_valid = r1v;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    resp_ready = rr;
  endtask

  initial begin
    // Starts after reset; last_grant resets to 1 so req0 wins ties first
    vt[0]  = mk(1, 0, 32'hFFFFFFFB, 32'd3, 32'd0, 32'd0, 1, 1, 0, 1, 0, 1);
    vt[1]  = mk(1, 1, 32'd5, 32'd5, 32'h80000000, 32'h7FFFFFFF, 1, 0, 1, 1, 1, 1);
    vt[2]  = mk(1, 1, 32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0, 1, 1, 0, 1, 0, 0);
    vt[3]  = mk(1, 1, 32'd0, 32'd0, 32'd7, 32'd7, 1, 0, 1, 1, 1, 0);
    vt[4]  = mk(1, 1, 32'hFFFFFFFF, 32'd0, 32'd1, 32'd0, 1, 1, 0, 1, 0, 1);
    // Stall: held result stays, nobody is ready, pointer stays at 0
    vt[5]  = mk(1, 1, 32'd9, 32'd1, 32'd100, 32'hFFFFFF9C, 0, 0, 0, 1, 0, 1);
    vt[6]  = mk(1, 1, 32'd9, 32'd1, 32'd100, 32'hFFFFFF9C, 0, 0, 0, 1, 0, 1);
    vt[7]  = mk(1, 1, 32'd9, 32'd1, 32'd100, 32'hFFFFFF9C, 0, 0, 0, 1, 0, 1);
    vt[8]  = mk(1, 1, 32'd9, 32'd1, 32'd100, 32'hFFFFFF9C, 1, 0, 1, 1, 1, 0);
    // Drain without a new accept, then idle
    vt[9]  = mk(0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 1, 0, 0, 0, 0, 0);
    vt[10] = mk(0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0);
    // Accept into empty stage with resp_ready low, then blocked while full
    vt[11] = mk(0, 1, 32'd0, 32'd0, 32'h80000000, 32'h80000000, 0, 0, 1, 1, 1, 0);
    vt[12] = mk(1, 0, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd0, 32'd0, 0, 0, 0, 1, 1, 0);
    vt[13] = mk(1, 0, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd0, 32'd0, 1, 1, 0, 1, 0, 1);

    rst = 1'b1;
    drive(1, 1, 32'd1, 32'd2, 32'd3, 32'd4, 1);
    #1;
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_lt", 32'(resp_lt), 32'd0);
    chk("rst_req0_ready", 32'(req0_ready), 32'd0);
    chk("rst_req1_ready", 32'(req1_ready), 32'd0);
`ifdef CMP_ARBITER_STATS_EN
    chk("rst_cnt0", 32'(grant_cnt0), 32'd0);
    chk("rst_cnt1", 32'(grant_cnt1), 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i].r0v, vt[i].r1v, vt[i].a0, vt[i].b0, vt[i].a1, vt[i].b1, vt[i].rr);
      #1;
      chk($sformatf("v%0d_req0_ready", i), 32'(req0_ready), 32'(vt[i].e_r0));
      chk($sformatf("v%0d_req1_ready", i), 32'(req1_ready), 32'(vt[i].e_r1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(vt[i].e_v));
      if (vt[i].e_v) begin
        chk($sformatf("v%0d_resp_id", i), 32'(resp_id), 32'(vt[i].e_id));
        chk($sformatf("v%0d_resp_lt", i), 32'(resp_lt), 32'(vt[i].e_lt));
      end
      @(negedge clk);
    end

    // Reset while FULL drops the held result at once
    chk("pre_rst_full", 32'(resp_valid), 32'd1);
    rst = 1'b1;
    drive(1, 1, 32'd1, 32'd2, 32'd2, 32'd1, 0);
    #1;
    chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
    chk("midrst_req0_ready", 32'(req0_ready), 32'd0);
    chk("midrst_req1_ready", 32'(req1_ready), 32'd0);
    chk("midrst_resp_id", 32'(resp_id), 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_hold_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    resp_ready = 1'b1;

    // Both valid after reset: grants 0,1,0,1 from the first free cycle
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("rr%0d_req0_ready", k), 32'(req0_ready), 32'((k % 2) == 0));
      chk($sformatf("rr%0d_req1_ready", k), 32'(req1_ready), 32'((k % 2) == 1));
      @(posedge clk);
      #1;
      chk($sformatf("rr%0d_resp_valid", k), 32'(resp_valid), 32'd1);
      chk($sformatf("rr%0d_resp_id", k), 32'(resp_id), 32'(k % 2));
      chk($sformatf("rr%0d_resp_lt", k), 32'(resp_lt), 32'((k % 2) == 0));
      @(negedge clk);
    end

`ifdef CMP_ARBITER_STATS_EN
    // Long run from req1 only: its counter saturates, req0's stays 0
    rst = 1'b1;
    #1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 32'd0, 32'd0, 32'd5, 32'd6, 1);
    repeat (70000) @(posedge clk);
    #1;
    chk("cnt1_saturated", 32'(grant_cnt1), 32'h0000FFFF);
    chk("cnt0_zero", 32'(grant_cnt0), 32'd0);
`endif

    drive(0, 0, 32'd0, 32'd0, 32'd0, 32'd0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_cmp_arbiter
